// File: rtl/debug_instruction_loader_pkg.sv
// Shared definitions for the debug instruction loader: FSM encoding, command bytes
// and the halt word.
package debug_instruction_loader_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StRun  = 3'd2,
    StStep = 3'd3,
    StDone = 3'd4
  } state_e;

  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_CONT = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
  localparam logic [7:0] CMD_NEXT = 8'h4E;  // 'N'
  localparam logic [7:0] CMD_QUIT = 8'h51;  // 'Q'

  localparam logic [31:0] HALT_INST_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/debug_instruction_loader_byte_word_assembler.sv
// Shifts received bytes MSB-first into a word; flags the cycle the last byte arrives,
// presenting the completed word combinationally in that same cycle.
module debug_instruction_loader_byte_word_assembler #(
  parameter int unsigned SizeInst = 32,
  parameter int unsigned SizeByte = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                valid_i,
  input  logic [SizeByte-1:0] rx_byte_i,
  output logic [SizeInst-1:0] word_o,
  output logic                word_done_o
);

  logic [SizeInst-1:0] word_q;
  logic [1:0]          cnt_q;

  assign word_o      = {word_q[SizeInst-SizeByte-1:0], rx_byte_i};
  assign word_done_o = valid_i && (cnt_q == 2'd3);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (clear_i) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (valid_i) begin
      word_q <= word_o;
      cnt_q  <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/debug_instruction_loader.sv
// Debug front end for the IF stage: loads a program from UART bytes into program memory,
// then sequences continuous or single-step execution until the pipeline halts.
module debug_instruction_loader
  import debug_instruction_loader_pkg::*;
#(
  parameter int unsigned          SIZE_INST = 32,
  parameter int unsigned          SIZE_BYTE = 8,
  parameter int unsigned          MEM_DEPTH = 64,
  parameter int unsigned          SIZE_ADDR = 32,
  parameter logic [SIZE_INST-1:0] HALT_INST = HALT_INST_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [SIZE_BYTE-1:0] i_rx_data,
  input  logic                 i_rx_done,
  input  logic                 i_flag_halt,
  output logic [SIZE_INST-1:0] o_instruction_debug,
  output logic                 o_flag_instruction_debug,
  output logic [SIZE_ADDR-1:0] o_inst_addr,
  output logic                 o_flag_start_pc,
  output logic                 o_enable,
  output logic                 o_load_done,
  output logic                 o_overflow,
  output logic [2:0]           o_state
);

  // One extra bit so an index equal to MEM_DEPTH is representable.
  localparam int unsigned IdxW = $clog2(MEM_DEPTH) + 1;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d, idx_inc;
  logic            load_done_q, load_done_d;
  logic            overflow_q, overflow_d;
  logic            step_pulse_q, step_pulse_d;

  logic                 asm_clear, asm_valid, word_done, wr;
  logic [SIZE_INST-1:0] word;

  assign asm_valid = (state_q == StLoad) && i_rx_done;
  assign wr        = word_done && (idx_q < IdxW'(MEM_DEPTH));
  assign idx_inc   = idx_q + 1'b1;

  debug_instruction_loader_byte_word_assembler #(
    .SizeInst(SIZE_INST),
    .SizeByte(SIZE_BYTE)
  ) u_assembler (
    .clk_i      (i_clk),
    .rst_ni     (i_reset),
    .clear_i    (asm_clear),
    .valid_i    (asm_valid),
    .rx_byte_i  (i_rx_data),
    .word_o     (word),
    .word_done_o(word_done)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      load_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
      step_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      load_done_q  <= load_done_d;
      overflow_q   <= overflow_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    load_done_d  = load_done_q;
    overflow_d   = overflow_q;
    step_pulse_d = 1'b0;
    asm_clear    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_rx_done) begin
          if (i_rx_data == CMD_LOAD) begin
            idx_d       = '0;
            load_done_d = 1'b0;
            overflow_d  = 1'b0;
            asm_clear   = 1'b1;
            state_d     = StLoad;
          end else if (i_rx_data == CMD_CONT && load_done_q) begin
            state_d = StRun;
          end else if (i_rx_data == CMD_STEP && load_done_q) begin
            state_d = StStep;
          end
        end
      end
      StLoad: begin
        if (wr) begin
          idx_d = idx_inc;
          if (word == HALT_INST) begin
            load_done_d = 1'b1;
            state_d     = StIdle;
          end else if (idx_inc == IdxW'(MEM_DEPTH)) begin
            overflow_d = 1'b1;
            state_d    = StIdle;
          end
        end
      end
      StRun: begin
        if (i_flag_halt) state_d = StDone;
      end
      StStep: begin
        // Halt takes priority over a coincident step request.
        if (i_flag_halt) begin
          state_d = StDone;
        end else if (i_rx_done) begin
          if (i_rx_data == CMD_NEXT) step_pulse_d = 1'b1;
          else if (i_rx_data == CMD_QUIT) state_d = StIdle;
        end
      end
      StDone: begin
        if (i_rx_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_flag_instruction_debug = wr;
    o_instruction_debug      = wr ? word : '0;
    o_inst_addr              = SIZE_ADDR'({idx_q, 2'b00});
    o_flag_start_pc          = (state_q == StRun) || (state_q == StStep);
    o_enable                 = (state_q == StRun) || ((state_q == StStep) && step_pulse_q);
    o_load_done              = load_done_q;
    o_overflow               = overflow_q;
    o_state                  = state_q;
  end

endmodule

// File: tb/tb_debug_instruction_loader.sv
// Randomized scoreboard bench for debug_instruction_loader with a command-level model.
module tb_debug_instruction_loader;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        flag_halt = 1'b0;
  logic [31:0] instruction_debug;
  logic        flag_instruction_debug;
  logic [31:0] inst_addr;
  logic        flag_start_pc;
  logic        enable;
  logic        load_done;
  logic        overflow;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;

  debug_instruction_loader #(
    .MEM_DEPTH(DEPTH)
  ) dut (
    .i_clk                   (clk),
    .i_reset                 (rst_n),
    .i_rx_data               (rx_data),
    .i_rx_done               (rx_done),
    .i_flag_halt             (flag_halt),
    .o_instruction_debug     (instruction_debug),
    .o_flag_instruction_debug(flag_instruction_debug),
    .o_inst_addr             (inst_addr),
    .o_flag_start_pc         (flag_start_pc),
    .o_enable                (enable),
    .o_load_done             (load_done),
    .o_overflow              (overflow),
    .o_state                 (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: modes 0 idle, 1 load, 2 run, 3 step, 4 done.
  int          m_mode = 0;
  int          m_idx = 0;
  bit          m_done = 0;
  bit          m_ovf = 0;
  bit          m_pulse = 0;
  logic [7:0]  m_bytes[$];
  logic [63:0] exp_q[$];  // {addr, data}
  int          writes_seen = 0;

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_done = 0; m_ovf = 0; m_pulse = 0;
    m_bytes.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [31:0] w;
    case (m_mode)
      0: begin
        if (b == 8'h4C) begin
          m_idx = 0; m_done = 0; m_ovf = 0; m_bytes.delete(); m_mode = 1;
        end else if (b == 8'h43 && m_done) m_mode = 2;
        else if (b == 8'h53 && m_done) m_mode = 3;
      end
      1: begin
        m_bytes.push_back(b);
        if (m_bytes.size() == 4) begin
          w = (32'(m_bytes[0]) << 24) + (32'(m_bytes[1]) << 16)
            + (32'(m_bytes[2]) << 8) + 32'(m_bytes[3]);
          exp_q.push_back({32'(m_idx * 4), w});
          m_idx++;
          m_bytes.delete();
          if (w == 32'hFFFF_FFFF) begin
            m_done = 1; m_mode = 0;
          end else if (m_idx == DEPTH) begin
            m_ovf = 1; m_mode = 0;
          end
        end
      end
      3: begin
        if (b == 8'h4E) m_pulse = 1;
        else if (b == 8'h51) m_mode = 0;
      end
      4: m_mode = 0;
      default: ;
    endcase
  endtask

  // Scoreboard monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (rst_n && flag_instruction_debug) begin
      writes_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", inst_addr, 32'hxxxx_xxxx);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("write_addr", inst_addr, e[63:32]);
        check("write_data", instruction_debug, e[31:0]);
      end
    end
  end

  task automatic check_model(input string tag);
    check({tag, "_state"}, 32'(state), 32'(m_mode));
    check({tag, "_load_done"}, 32'(load_done), 32'(m_done));
    check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, "_start_pc"}, 32'(flag_start_pc), 32'(m_mode == 2 || m_mode == 3));
    check({tag, "_enable"}, 32'(enable), 32'(m_mode == 2 || (m_mode == 3 && m_pulse)));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit halt);
    @(posedge clk);
    #1;
    rx_data = b;
    rx_done = 1'b1;
    flag_halt = halt;
    if (halt && (m_mode == 2 || m_mode == 3)) m_mode = 4;
    else model_byte(b);
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    flag_halt = 1'b0;
    rx_data = 8'($urandom);
    check_model("byte");
    m_pulse = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rx_data = 8'($urandom);
      check_model("idle");
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8], 1'b0);
      if (gaps) idle_cycles($urandom_range(0, 2));
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == 32'hFFFF_FFFF) w = 32'h0;
    return w;
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_outputs", {25'(0), flag_instruction_debug, flag_start_pc, enable, load_done,
                          overflow, 2'b00}, 32'd0);
    check("rst_addr", inst_addr, 32'd0);
    check("rst_instr", instruction_debug, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ws;
    do_reset();
    check_model("post_reset");

    // Guard: run/step requests without a resident program.
    send_byte(8'h43, 1'b0);
    send_byte(8'h53, 1'b0);

    // Directed load of one word plus HALT.
    send_byte(8'h4C, 1'b0);
    send_word(32'h0000_0001, 1'b0);
    send_word(32'hFFFF_FFFF, 1'b0);
    check("load_pending", 32'(exp_q.size()), 32'd0);

    // Continuous run, halt raised after 20 run cycles.
    send_byte(8'h43, 1'b0);
    idle_cycles(19);
    @(posedge clk);
    #1;
    flag_halt = 1'b1;
    m_mode = 4;
    @(posedge clk);
    #1;
    flag_halt = 1'b0;
    check_model("run_halt");
    send_byte(8'($urandom_range(0, 255)), 1'b0);

    // Single step: three pulses, then a step request coincident with halt.
    send_byte(8'h53, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h4E, 1'b0);
      idle_cycles($urandom_range(1, 3));
    end
    send_byte(8'h4E, 1'b1);
    idle_cycles(2);
    send_byte(8'h51, 1'b0);
    send_byte(8'h53, 1'b0);
    send_byte(8'h51, 1'b0);

    // Randomized programs, 0..3 words before HALT, with random byte gaps.
    for (int it = 0; it < 6; it++) begin
      send_byte(8'h4C, 1'b0);
      for (int n = $urandom_range(0, 3); n > 0; n--) send_word(rand_word(), 1'b1);
      send_word(32'hFFFF_FFFF, 1'b1);
      idle_cycles(1);
    end

    // Overflow: more non-HALT words than memory holds.
    ws = writes_seen;
    send_byte(8'h4C, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      logic [31:0] w;
      w = rand_word();
      for (int k = 0; k < 4; k++) if (w[8*k +: 8] == 8'h4C) w[8*k +: 8] = 8'h00;
      send_word(w, 1'b1);
    end
    check("overflow_writes", 32'(writes_seen - ws), 32'(DEPTH));
    send_byte(8'h43, 1'b0);

    // Reset in the middle of a word, then reload a lone HALT.
    send_byte(8'h4C, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    do_reset();
    check_model("mid_reset");
    send_byte(8'h43, 1'b0);
    ws = writes_seen;
    send_byte(8'h4C, 1'b0);
    send_word(32'hFFFF_FFFF, 1'b0);
    check("reload_writes", 32'(writes_seen - ws), 32'd1);
    idle_cycles(2);

    check("final_pending", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debug_instruction_loader.md
Name: debug_instruction_loader

Overview:
- Debug-side front end that feeds the IF stage.
- Consumes bytes from the UART receiver and assembles them into 32-bit instructions, which it writes into program memory through the debug instruction port.
- Sequences program execution once loading completes: continuous run or single-step.
- Drives the IF-stage start, enable and debug-write controls, and reacts to the pipeline halt flag.

Parameters:
- SIZE_INST, 32, instruction/word width.
- SIZE_BYTE, 8, UART byte width.
- MEM_DEPTH, 64, program memory capacity in words.
- SIZE_ADDR, 32, byte-address width of o_inst_addr.
- HALT_INST, 32'hFFFFFFFF, encoding that terminates loading and execution.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-low reset
- i_rx_data  in  SIZE_BYTE  received byte, valid when i_rx_done=1
- i_rx_done  in  1  one-cycle strobe from the UART RX
- i_flag_halt  in  1  halt reached by the pipeline (level)
- o_instruction_debug  out  SIZE_INST  assembled instruction
- o_flag_instruction_debug  out  1  one-cycle program-memory write strobe
- o_inst_addr  out  SIZE_ADDR  byte address of the current write (word index * 4)
- o_flag_start_pc  out  1  program running/advancing (level)
- o_enable  out  1  pipeline/PC enable
- o_load_done  out  1  valid program resident
- o_overflow  out  1  sticky: program exceeded MEM_DEPTH
- o_state  out  3  current FSM state, for debug readout

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: every output is 0; state=IDLE; byte counter=0; word index=0; assembly register=0.
- Only cycles with i_rx_done=1 consume a byte. i_rx_data is ignored otherwise.
- IDLE:
  - 'L' (0x4C): clear word index, o_load_done and o_overflow; go to LOAD.
  - 'C' (0x43): go to RUN, only if o_load_done=1.
  - 'S' (0x53): go to STEP, only if o_load_done=1.
  - Any other byte, or C/S with o_load_done=0: stay in IDLE.
- LOAD:
  - Bytes are shifted in MSB first: word = {word[23:0], byte}. A 2-bit counter tracks the byte position.
  - On the 4th byte, in the same cycle: o_instruction_debug is driven combinationally from {word[23:0], byte} and o_flag_instruction_debug=1 for exactly that cycle. o_inst_addr = index*4, so write latency is 0 cycles after the last byte strobe.
  - The word index then increments and the counter wraps to 0.
  - If the written word == HALT_INST: o_load_done=1 and go to IDLE. The HALT word is itself written.
  - If index reaches MEM_DEPTH without a HALT: no further writes, o_overflow=1, o_load_done stays 0, go to IDLE.
  - Partial words never produce a write strobe.
- RUN:
  - o_flag_start_pc=1 and o_enable=1 every cycle.
  - i_flag_halt=1 → go to DONE at the next edge, with both outputs 0 from that edge on.
  - Received bytes are ignored.
- STEP:
  - o_flag_start_pc=1; o_enable=0 by default.
  - Each 'N' (0x4E) byte raises o_enable for exactly one cycle, the cycle after the strobe.
  - i_flag_halt=1 → go to DONE. If halt and a step request coincide, halt wins and no enable pulse is issued.
  - 'Q' (0x51) aborts to IDLE.
- DONE:
  - o_flag_start_pc=0, o_enable=0, o_load_done held.
  - Any received byte returns to IDLE without being decoded.
- Reset mid-LOAD: any partial word is discarded, o_load_done=0, and the loaded program is considered invalid.
- Address arithmetic: o_inst_addr = {index, 2'b00} truncated or zero-extended to SIZE_ADDR. The index counter is clog2(MEM_DEPTH)+1 bits wide, so reaching MEM_DEPTH is detectable without wrap.

Decomposition:
- Shared package holds:
  - state encodings IDLE=0, LOAD=1, RUN=2, STEP=3, DONE=4;
  - command byte constants CMD_LOAD, CMD_CONT, CMD_STEP, CMD_NEXT, CMD_QUIT;
  - HALT_INST default.
- One natural sub-module: byte_word_assembler (shift register plus 2-bit counter producing a word-complete strobe). The FSM stays in the top module.

Test Plan:
- Load: 'L', then 00 00 00 01, then FF FF FF FF → two write strobes, with addr 0 data 0x00000001 and addr 4 data 0xFFFFFFFF; o_load_done=1; state IDLE.
- Run: after a valid load, send 'C' → o_flag_start_pc=o_enable=1; assert i_flag_halt at cycle 20 → both outputs 0 from the next edge; state DONE.
- Step: after a load, send 'S', then three 'N' bytes → exactly three single-cycle o_enable pulses; 'N' coincident with i_flag_halt → no pulse; state DONE.
- Guard: 'C' or 'S' with no program loaded → state stays IDLE and all control outputs stay 0.
- Overflow: with MEM_DEPTH=4, load 5 non-HALT words → exactly 4 strobes (addrs 0, 4, 8, 12); o_overflow=1; o_load_done=0.
- Reset mid-word: 'L', then 2 bytes, pulse i_reset low, then 'L' and a full HALT word → a single write at addr 0 with no corrupted high bytes.
